// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of a word-addressed data memory.
// Accepts byte/half/word loads and stores on byte addresses. Loads return
// sign- or zero-extended data. Sub-word stores are done as read-modify-write,
// because the memory only writes whole words.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  state_t state_reg, state_next;

  // Request fields latched at acceptance
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic [1:0]  lo_reg;
  logic [31:0] wdata_reg;
  logic        err_reg;
  logic [29:0] index_reg;
  logic [31:0] merge_reg;
  logic [31:0] rdata_reg;

  logic        accept;
  logic        req_err;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [3:0]  lane_en;
  logic [31:0] wdata_rep;
  logic [31:0] merge_next;

  // ready, write enable and response valid are all forced low while reset is held
  assign req_ready  = (state_reg == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign mem_we     = (state_reg == WRITE) && !reset;
  assign resp_valid = (state_reg == RESP) && !reset;
  assign resp_err   = resp_valid && err_reg;
  assign resp_rdata = rdata_reg;
  assign mem_addr   = {2'b00, index_reg};
  assign mem_wd     = mem_we ? ((size_reg == 2'd2) ? wdata_reg : merge_reg) : 32'h0;

  // Misaligned, illegal-size or out-of-range requests never touch memory
  assign req_err = (req_size == 2'd3)
                || ((req_size == 2'd1) && req_addr[0])
                || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                || ({2'b00, req_addr[31:2]} >= MEM_WORDS_U);

  // Load lane extraction and extension (little-endian lanes)
  assign load_byte = mem_rd[{lo_reg, 3'b000} +: 8];
  assign load_half = mem_rd[{lo_reg[1], 4'b0000} +: 16];

  // Pick the addressed lane out of the read word and extend it
  always_comb begin
    load_ext = mem_rd;
    case (size_reg)
      2'd0:    load_ext = {{24{signed_reg & load_byte[7]}}, load_byte};
      2'd1:    load_ext = {{16{signed_reg & load_half[15]}}, load_half};
      default: load_ext = mem_rd;
    endcase
  end

  // Store merge: replicate the store data across lanes, then replace only
  // the lanes being written and keep the rest of the read word untouched
  assign lane_en   = (size_reg == 2'd0) ? (4'b0001 << lo_reg)
                                        : (lo_reg[1] ? 4'b1100 : 4'b0011);
  assign wdata_rep = (size_reg == 2'd0) ? {4{wdata_reg[7:0]}} : {2{wdata_reg[15:0]}};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merge_next[8*gi +: 8] = lane_en[gi] ? wdata_rep[8*gi +: 8] : mem_rd[8*gi +: 8];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_err)              state_next = RESP;
          else if (!req_we)         state_next = LOAD;
          else if (req_size == 2'd2) state_next = WRITE;
          else                      state_next = RMW_RD;
        end
      end
      LOAD:    state_next = RESP;
      RMW_RD:  state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, load result capture and merge buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_reg   <= 2'd0;
      signed_reg <= 1'b0;
      lo_reg     <= 2'd0;
      wdata_reg  <= 32'h0;
      err_reg    <= 1'b0;
      index_reg  <= 30'h0;
      merge_reg  <= 32'h0;
      rdata_reg  <= 32'h0;
    end else begin
      if (accept) begin
        size_reg   <= req_size;
        signed_reg <= req_signed;
        lo_reg     <= req_addr[1:0];
        wdata_reg  <= req_wdata;
        err_reg    <= req_err;
        index_reg  <= req_addr[31:2];
        // stores and errors report zero data
        rdata_reg  <= 32'h0;
      end
      if (state_reg == LOAD) begin
        rdata_reg <= load_ext;
      end
      if (state_reg == RMW_RD) begin
        merge_reg <= merge_next;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the word-addressed data memory interface: accepts byte/halfword/word load and store requests from the pipeline on byte addresses, drives the memory's word address, write data and write enable, and returns sign/zero-extended load data. Sub-word stores are performed as read-modify-write, because the memory only writes full words. Sits between the MEM pipeline stage and the data memory.

## Interface
- MEM_WORDS, 64, number of 32-bit words in the attached memory; word indices >= MEM_WORDS are errors
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for sub-word stores
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualified by resp_valid; request was misaligned, illegal or out of range
- resp_rdata  out  32  load result, qualified by resp_valid; 0 for stores and errors
- mem_addr  out  32  word index, equal to req_addr[31:2] zero-extended
- mem_wd  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  32  memory read data, combinational from mem_addr

## Operation
- Lane mapping is little-endian: byte k = bits [8k+7:8k] and half h = bits [16h+15:16h] of the word.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. All request fields are latched at that edge; inputs are ignored while the unit is busy.
- Error check at acceptance. An error is any of:
  - size 3;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[31:2] >= MEM_WORDS.
  An errored request goes to RESP with no memory access (mem_we never asserted).
- States:
  - IDLE: req_ready = 1. On acceptance, the next state is LOAD, WRITE (word store), RMW_RD (byte/half store) or RESP (error).
  - LOAD: mem_addr = latched word index. Extract the lane from mem_rd, extend it per req_signed, capture into resp_rdata, then go to RESP.
  - RMW_RD: mem_addr = word index. Capture mem_rd into the merge buffer with the target lane replaced by req_wdata[7:0] or [15:0], then go to WRITE.
  - WRITE: mem_we = 1, mem_wd = req_wdata (word store) or the merge buffer, then go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, resp_err as computed, then go to IDLE. There is no response backpressure.
- mem_we is asserted only in WRITE. mem_addr holds the latched index from acceptance until the next acceptance.
- Store data is never sign-affected; req_signed is ignored for stores.
- Only the lane being stored changes; the other three (or two) bytes of the word are preserved exactly.

## Timing
- Acceptance occurs at edge T.
- Load: LOAD during cycle T+1, resp_valid during T+2. Latency 2; a new request can be accepted at the end of T+3 (IDLE again in T+3).
- Word store: WRITE during T+1 (memory written at the edge ending T+1), resp_valid during T+2.
- Byte/half store: RMW_RD during T+1, WRITE during T+2, resp_valid during T+3.
- Error: resp_valid and resp_err during T+1.
- Reset (asynchronous, any state):
  - state goes to IDLE;
  - mem_we, resp_valid, resp_err and req_ready are 0 while reset is asserted;
  - mem_addr, mem_wd, resp_rdata and the merge buffer are 0;
  - req_ready rises in the first cycle after reset deasserts.
- Reset mid-RMW aborts before WRITE, leaving memory unchanged. Reset asserted during WRITE drops mem_we immediately, so no write occurs at the next edge.
- req_valid held high during RESP is not accepted until IDLE.

## Test plan
- Reset, then word store 0xDEADBEEF to addr 0x10, then word load from 0x10: mem_we pulses once with mem_addr = 4; the load returns 0xDEADBEEF, with resp_valid 2 cycles after each acceptance.
- With word 4 = 0x11223344: store byte 0xAB at addr 0x12 -> word 4 becomes 0x11AB3344. Then store half 0xCDEF at 0x10 -> word 4 becomes 0x11ABCDEF. Each store's resp_valid arrives 3 cycles after acceptance.
- With word 4 = 0x80FF7F01: signed byte load from 0x12 -> 0xFFFFFFFF; unsigned -> 0x000000FF; signed half load from 0x12 -> 0xFFFF80FF; signed byte load from 0x10 -> 0x00000001.
- Errors: half load from 0x11, word store to 0x12, size 3, and word load from 0x100 (index 64 with MEM_WORDS = 64) -> each gives resp_valid with resp_err = 1 one cycle after acceptance, mem_we stays 0, and memory is unchanged.
- Assert reset during RMW_RD of a byte store to 0x20 -> word 8 is unchanged, all outputs are 0, and req_ready returns 1 after release.
- Hold req_valid high continuously across back-to-back loads -> acceptances occur only in IDLE, and each request yields exactly one resp_valid pulse.
